// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider arbiter: FSM states, default sizes,
// core latency and the round-robin winner search.
package div_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int DEF_W     = 8;
  localparam int DEF_N_REQ = 4;
  localparam int CORE_LAT  = DEF_W + 1;

  // First set bit of req searching upward from ptr+1 with wrap over n entries.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr,
                                         input int n);
    logic [3:0] win;
    int idx;
    win = ptr;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(ptr) + k) % n;
      if (req[idx]) win = 4'(idx);
    end
    return win;
  endfunction

endpackage

// File: rtl/div_arb_if.sv
// Client-side bus of the divider arbiter: level requests with packed operands
// in, one-hot ack with shared result out.
interface div_arb_if
  import div_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] div1_bus;
  logic [N_REQ*W-1:0] div2_bus;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       quo;
  logic [W-1:0]       resto;
  logic               zero_div;
  logic               busy;
  logic [GW-1:0]      grant_id;

  modport master (
    output req, div1_bus, div2_bus,
    input  ack, quo, resto, zero_div, busy, grant_id
  );

  modport slave (
    input  req, div1_bus, div2_bus,
    output ack, quo, resto, zero_div, busy, grant_id
  );

endinterface

// File: rtl/div_arb_core.sv
// Sequential restoring divider: loads on start, then W shift-subtract steps;
// a zero divisor finishes on the load edge with saturated quotient.
module div_core
  import div_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quo,
  output logic [W-1:0] resto,
  output logic         zero_div
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  dsr;
  logic [CW-1:0] cnt;
  logic          run;
  logic [W:0]    shifted;
  logic [W:0]    diff;

  // diff[W] is the borrow: set when the shifted remainder is below the divisor.
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dsr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      done     <= 1'b0;
      quo      <= '0;
      zero_div <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dsr      <= divisor;
        zero_div <= (divisor == '0);
        if (divisor == '0) begin
          quo  <= '1;
          rem  <= dividend;
          run  <= 1'b0;
          done <= 1'b1;
        end else begin
          quo <= dividend;
          rem <= '0;
          cnt <= CW'(W);
          run <= 1'b1;
        end
      end else if (run) begin
        if (!diff[W]) begin
          rem <= diff[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= shifted[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign resto = rem;

endmodule

// File: rtl/div_arb.sv
// Round-robin arbiter owning one div_core. Define DIV_ARB_FIXED_PRIO_EN for
// fixed lowest-index-wins priority instead of round-robin.
module div_arb
  import div_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
) (
  input  logic      clk,
  input  logic      reset_n,
  div_arb_if.slave  bus
);
  localparam int GW = $clog2(N_REQ);

  state_t           state;
  state_t           state_nxt;
  logic [GW-1:0]    grant_id;
  logic [GW-1:0]    pick;
  logic [W-1:0]     dvd;
  logic [W-1:0]     dsr;
  logic             core_start;
  logic             core_done;
  logic [W-1:0]     core_quo;
  logic [W-1:0]     core_rem;
  logic             core_zero;
  logic [N_REQ-1:0] ack;
  logic [W-1:0]     quo;
  logic [W-1:0]     resto;
  logic             zero_div;
  logic             busy;
  logic [15:0]      req_ext;

  assign req_ext = 16'(bus.req);

`ifdef DIV_ARB_FIXED_PRIO_EN
  // Searching from the last index upward makes index 0 the first candidate.
  assign pick = GW'(rr_pick(req_ext, 4'(N_REQ - 1), N_REQ));
`else
  logic [GW-1:0] ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            ptr <= GW'(N_REQ - 1);
    else if (state == S_WAIT && core_done)   ptr <= grant_id;
  end

  assign pick = GW'(rr_pick(req_ext, 4'(ptr), N_REQ));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|bus.req) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (core_done) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // Grant capture, core start pulse and result/ack registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id   <= '0;
      dvd        <= '0;
      dsr        <= '0;
      core_start <= 1'b0;
      ack        <= '0;
      quo        <= '0;
      resto      <= '0;
      zero_div   <= 1'b0;
    end else begin
      core_start <= 1'b0;
      ack        <= '0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            grant_id   <= pick;
            dvd        <= bus.div1_bus[int'(pick)*W +: W];
            dsr        <= bus.div2_bus[int'(pick)*W +: W];
            core_start <= 1'b1;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            quo           <= core_quo;
            resto         <= core_rem;
            zero_div      <= core_zero;
            ack[grant_id] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  div_core #(.W(W)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (core_start),
    .dividend (dvd),
    .divisor  (dsr),
    .done     (core_done),
    .quo      (core_quo),
    .resto    (core_rem),
    .zero_div (core_zero)
  );

  assign bus.ack      = ack;
  assign bus.quo      = quo;
  assign bus.resto    = resto;
  assign bus.zero_div = zero_div;
  assign bus.busy     = busy;
  assign bus.grant_id = grant_id;

endmodule

// File: doc/div_arb.md
Name: div_arb

Overview:
- Shares one sequential W-bit unsigned divider engine among N_REQ requesters.
- Round-robin arbitration; grants one requester per operation.
- Latches the winner's operands, sequences the engine's start/done, and returns quotient, remainder and divide-by-zero flag with a one-cycle per-requester ack.
- Sits between the arithmetic clients and the divider core; the sole owner of the core.

Parameters:
N_REQ, 4, number of requesters (2..16)
W, 8, operand/result width (4..32)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  N_REQ  level request per requester; held until its ack
div1_bus  in  N_REQ*W  dividends, requester i at [i*W +: W]
div2_bus  in  N_REQ*W  divisors, same packing
ack  out  N_REQ  one-hot, one-cycle pulse: result for requester i valid this cycle
quo  out  W  quotient of last completed op
resto  out  W  remainder of last completed op
zero_div  out  1  last completed op had divisor 0
busy  out  1  high in every state except IDLE
grant_id  out  clog2(N_REQ)  requester being served; valid while busy

Behaviour:
- Reset (async assert, sync release):
  - ack=0, quo=0, resto=0, zero_div=0, busy=0, grant_id=0.
  - FSM=IDLE; rr pointer=N_REQ-1, so requester 0 has first priority.
  - Divider core cleared.
  - Reset mid-operation aborts the op; no ack is ever issued for it.
- FSM states: IDLE, START, WAIT, RESP.
  - IDLE: on an edge with req!=0, pick the first set bit searching from ptr+1 upward with wrap. Register grant_id and that requester's div1/div2, pulse core start, go to START. If req==0, stay.
  - START: core samples start and loads; go to WAIT.
  - WAIT: on core done, register quo/resto/zero_div, set ack[grant_id]=1, ptr<=grant_id, go to RESP.
  - RESP: clear ack, go to IDLE.
- Latency, measured from request-sampling edge E0:
  - Nonzero divisor: ack high after edge E0+W+2.
  - Zero divisor: ack high after edge E0+2.
  - Back-to-back throughput: one op per W+4 clocks.
- Core (div_core):
  - Restoring shift-subtract; W iterations after the load cycle.
  - Divisor 0 gives done one edge after start, with quo={W{1}}, resto=dividend, zero_div=1.
- Handshake:
  - Requester holds req and operands until ack, then drops req on the next edge.
  - req still high in IDLE after RESP is treated as a new request.
  - Operands are captured at grant; later changes are ignored.
  - req withdrawn during service is ignored: the op completes and ack still pulses.
  - Requests arriving while busy wait; no loss, no queueing beyond the req level.
- Results hold until the next completion; outputs are not cleared at RESP.
- Arithmetic is unsigned. Invariant: dividend = quo*divisor + resto, resto < divisor.

Optional Feature:
DIV_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; rr pointer is removed.
- Undefined: round-robin as above.
- Ports, latency and handshake are identical in both builds.

Decomposition:
- Package div_arb_pkg holds:
  - FSM state enum.
  - Default W and N_REQ.
  - Localparam CORE_LAT = W+1.
  - Function rr_pick(req, ptr) returning the winner index.
- One sub-module: div_core (start, dividend, divisor in; done, quo, resto, zero_div out), instantiated once.

Test Plan:
- Single op: W=8, req=0001, 100/7 -> ack=0001 after E0+10, quo=14, resto=2, zero_div=0, busy low after RESP.
- Zero divisor: req=0100, 55/0 -> ack=0100 after E0+2, zero_div=1, quo=255, resto=55.
- Simultaneous: req=1111 all held, each dropped after its ack -> acks in order 0,1,2,3, spaced 12 clocks; grant_id matches each ack.
- Fairness: req0 reasserts immediately after every ack, req3 held -> service order 0,3,0,3. With DIV_ARB_FIXED_PRIO_EN -> 0,0,0 (req3 starved).
- Reset mid-op: reset_n=0 during WAIT of 200/3 -> ack, busy and outputs 0 immediately. After release, req=0010 is served normally with no stale ack.
- Boundaries and operand capture:
  - 255/1 -> quo=255, resto=0.
  - 0/5 -> quo=0, resto=0.
  - 7/9 -> quo=0, resto=7.
  - div1 of the granted requester changed during WAIT -> result uses the captured value.
